// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch PC, synchronous instruction-memory reader and IR
// producer for the control state machine.
//
// Optional feature: define FETCH_PREFETCH_EN to add a one-entry prefetch
// buffer. With the buffer, one instruction per cycle can be sustained while
// ir_ready stays high. Without it, each instruction goes through
// REQ -> WAIT -> HOLD, and no read is issued while an instruction is held.
//
// Handshake: ir_valid=1 means IR/ir_pc hold an unconsumed instruction and
// stay stable until consumed. A transfer happens on a rising edge where
// ir_valid=1 and ir_ready=1, unless pc_load=1 in that cycle. In that case the
// redirect wins, and the presented word is dropped, not re-presented.
// ir_ready is ignored while ir_valid=0.
//
// imem_rd_en/imem_addr are combinational. Read data is sampled the cycle
// after imem_rd_en, and at most one read is outstanding at any time.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       IR,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;

`ifdef FETCH_PREFETCH_EN
  // pf_busy_q: a prefetch read was issued last cycle, so its data is on
  // imem_rdata now. pf_valid_q and pf_busy_q are never both set.
  logic [15:0]       pf_data_q, pf_data_d;
  logic [ADDR_W-1:0] pf_pc_q, pf_pc_d;
  logic              pf_valid_q, pf_valid_d;
  logic              pf_busy_q, pf_busy_d;
`endif

  assign IR        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign dbg_state = state_q;

  // Next-state, datapath updates and read strobe
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    imem_rd_en = 1'b0;
    imem_addr  = '0;
`ifdef FETCH_PREFETCH_EN
    pf_data_d  = pf_data_q;
    pf_pc_d    = pf_pc_q;
    pf_valid_d = pf_valid_q;
    pf_busy_d  = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_REQ;
      end
      S_REQ: begin
        imem_rd_en = 1'b1;
        imem_addr  = fetch_pc_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        ir_d       = imem_rdata;
        ir_pc_d    = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_ONE;
        ir_valid_d = 1'b1;
        state_d    = S_HOLD;
`ifdef FETCH_PREFETCH_EN
        // Pipeline the next read behind the one returning now, so the
        // buffer can be full by the first HOLD cycle.
        if (start) begin
          imem_rd_en = 1'b1;
          imem_addr  = fetch_pc_q + PC_ONE;
          pf_busy_d  = 1'b1;
        end
`endif
      end
      S_HOLD: begin
`ifdef FETCH_PREFETCH_EN
        if (ir_ready) begin
          if (pf_valid_q || pf_busy_q) begin
            // Advance straight to the buffered word (or to the word arriving
            // this cycle), keeping ir_valid high.
            ir_d       = pf_valid_q ? pf_data_q : imem_rdata;
            ir_pc_d    = pf_valid_q ? pf_pc_q : fetch_pc_q;
            pf_valid_d = 1'b0;
            if (!pf_valid_q) fetch_pc_d = fetch_pc_q + PC_ONE;
            if (start) begin
              imem_rd_en = 1'b1;
              imem_addr  = pf_valid_q ? fetch_pc_q : fetch_pc_q + PC_ONE;
              pf_busy_d  = 1'b1;
            end
          end else begin
            ir_valid_d = 1'b0;
            state_d    = start ? S_REQ : S_IDLE;
          end
        end else if (pf_busy_q) begin
          pf_data_d  = imem_rdata;
          pf_pc_d    = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + PC_ONE;
          pf_valid_d = 1'b1;
        end else if (!pf_valid_q && start) begin
          imem_rd_en = 1'b1;
          imem_addr  = fetch_pc_q;
          pf_busy_d  = 1'b1;
        end
`else
        if (ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = start ? S_REQ : S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // A redirect overrides everything above. The held word and any read in
    // flight are dropped, and no new read is started this cycle.
    if (pc_load) begin
      fetch_pc_d = pc_load_value;
      ir_d       = ir_q;
      ir_pc_d    = ir_pc_q;
      ir_valid_d = 1'b0;
      state_d    = start ? S_REQ : S_IDLE;
      imem_rd_en = 1'b0;
      imem_addr  = '0;
`ifdef FETCH_PREFETCH_EN
      pf_valid_d = 1'b0;
      pf_busy_d  = 1'b0;
`endif
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      ir_q       <= 16'd0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pf_data_q  <= 16'd0;
      pf_pc_q    <= '0;
      pf_valid_q <= 1'b0;
      pf_busy_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
`ifdef FETCH_PREFETCH_EN
      pf_data_q  <= pf_data_d;
      pf_pc_q    <= pf_pc_d;
      pf_valid_q <= pf_valid_d;
      pf_busy_q  <= pf_busy_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed latency, backpressure, redirect, stop
// and reset cases, plus random redirect segments. A reference stream model
// (target address, incrementing modulo 2^ADDR_W, words read from the memory
// image) fills exp_q, and a negedge monitor pops it on every transfer.
module tb_instr_fetch_unit;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset_n, start, ir_ready, pc_load;
  logic [AW-1:0] pc_load_value;
  logic [AW-1:0] imem_addr, ir_pc;
  logic          imem_rd_en, ir_valid;
  logic [15:0]   imem_rdata = 16'd0;
  logic [15:0]   IR;
  logic [1:0]    dbg_state;

  // clock / reset block
  always #5 clock = ~clock;

  instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(8'h00)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .IR(IR), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .dbg_state(dbg_state)
  );

  // synchronous instruction memory, 1-cycle read latency
  logic [15:0] mem [0:255];
  always @(posedge clock) if (imem_rd_en) imem_rdata <= mem[imem_addr];

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int cons_cnt = 0;
  int cons_cyc[$];
  logic [AW+15:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  // scoreboard monitor: checks every transfer and the stability of held words
  logic          prev_valid = 1'b0;
  logic          prev_moved = 1'b1;
  logic [15:0]   prev_ir;
  logic [AW-1:0] prev_pc;
  always @(negedge clock) begin
    logic [AW+15:0] e;
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_moved = 1'b1;
    end else begin
      if (ir_valid && prev_valid && !prev_moved) begin
        chk("hold_ir", IR, prev_ir);
        chk("hold_pc", ir_pc, prev_pc);
      end
      if (ir_valid && ir_ready && !pc_load) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_consume");
        end else begin
          e = exp_q.pop_front();
          chk("consume_ir", IR, e[15:0]);
          chk("consume_pc", ir_pc, e[AW+15:16]);
        end
        cons_cnt++;
        cons_cyc.push_back(cyc);
      end
      prev_moved = (ir_valid && ir_ready) || pc_load;
      prev_valid = ir_valid;
      prev_ir    = IR;
      prev_pc    = ir_pc;
    end
  end

  // driver tasks
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [AW-1:0] a);
    exp_q.push_back({a, mem[a]});
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    #1;
    while (!ir_valid && k < 30) begin
      next_cycle();
      #1;
      k++;
    end
    if (!ir_valid) fail_now(name);
  endtask

  task automatic consume_one();
    ir_ready = 1'b1;
    next_cycle();
    ir_ready = 1'b0;
  endtask

  // Redirect to tgt and expect n words from tgt, tgt+1, ... mod 2^AW
  task automatic run_segment(input logic [AW-1:0] tgt, input int n, input int pct);
    int goal, k, t;
    logic [AW-1:0] a;
    goal = cons_cnt + n;
    for (int i = 0; i < n; i++) begin
      t = (int'(tgt) + i) % (1 << AW);
      a = t[AW-1:0];
      push_exp(a);
    end
    pc_load = 1'b1;
    pc_load_value = tgt;
    ir_ready = 1'($urandom_range(0, 1));
    next_cycle();
    pc_load = 1'b0;
    k = 0;
    while (cons_cnt < goal && k < 40 * n + 20) begin
      ir_ready = ($urandom_range(1, 100) <= pct);
      next_cycle();
      k++;
    end
    ir_ready = 1'b0;
    if (cons_cnt < goal) fail_now("segment_timeout");
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
  endtask

  initial begin
    #300000;
    fail_now("watchdog");
    summary();
    $finish;
  end

  initial begin
    int reads, d, sz;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 16'hFFFF));
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'h0001;
    mem[8'h40] = 16'hBEEF;
    for (int i = 0; i < 4; i++) mem[8'h80 + i] = 16'(i + 1);

    reset_n = 1'b0; start = 1'b0; ir_ready = 1'b0; pc_load = 1'b0; pc_load_value = '0;
    repeat (2) next_cycle();
    #1;
    chk("rst_valid", ir_valid, 0);
    chk("rst_ir", IR, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_rd_en", imem_rd_en, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_state", dbg_state, 0);

    // basic fetch: start in cycle 0, read in cycle 1, valid in cycle 3
    next_cycle();
    reset_n = 1'b1;
    start = 1'b1;
    push_exp(8'h00);
    next_cycle(); #1;
    chk("c1_rd_en", imem_rd_en, 1);
    chk("c1_addr", imem_addr, 0);
    chk("c1_valid", ir_valid, 0);
    next_cycle(); #1;
    chk("c2_valid", ir_valid, 0);
`ifdef FETCH_PREFETCH_EN
    chk("c2_pf_rd_en", imem_rd_en, 1);
    chk("c2_pf_addr", imem_addr, 1);
`else
    chk("c2_rd_en", imem_rd_en, 0);
`endif
    next_cycle(); #1;
    chk("c3_valid", ir_valid, 1);
    chk("c3_ir", IR, 16'h1234);
    chk("c3_ir_pc", ir_pc, 0);

    // backpressure: ten cycles of ir_ready=0, no reads may issue
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_rd_en) reads++;
      chk("bp_valid", ir_valid, 1);
      next_cycle(); #1;
    end
    chk("bp_reads", reads, 0);
    chk("bp_ir", IR, 16'h1234);
    push_exp(8'h01);
    consume_one(); #1;
`ifdef FETCH_PREFETCH_EN
    chk("next_valid_pf", ir_valid, 1);
    chk("next_ir_pf", IR, 16'h0001);
`else
    chk("next_valid", ir_valid, 0);
    chk("next_rd_en", imem_rd_en, 1);
    chk("next_addr", imem_addr, 1);
`endif
    wait_valid("wait_word1");
    consume_one();

    // redirect while holding with ir_ready=1: pc_load wins
    wait_valid("wait_word2");
    push_exp(8'h40);
    pc_load = 1'b1; pc_load_value = 8'h40; ir_ready = 1'b1;
    next_cycle();
    pc_load = 1'b0; ir_ready = 1'b0;
    #1;
    chk("redir_valid", ir_valid, 0);
    chk("redir_rd_en", imem_rd_en, 1);
    chk("redir_addr", imem_addr, 8'h40);
    wait_valid("wait_beef");
    chk("redir_ir", IR, 16'hBEEF);
    consume_one();

    // wrap of the fetch PC, then random redirect segments
    run_segment(8'hFF, 3, 70);
    repeat (6) run_segment(8'($urandom_range(0, 255)), $urandom_range(2, 10), $urandom_range(30, 100));

    // throughput with ir_ready held high, then a redirect over a live prefetch
    run_segment(8'h80, 4, 100);
    sz = cons_cyc.size();
    d = (sz >= 4) ? cons_cyc[sz-1] - cons_cyc[sz-4] : -1;
`ifdef FETCH_PREFETCH_EN
    chk("pf_throughput", d, 3);
`else
    chk("throughput", d, 9);
`endif
    run_segment(8'h20, 3, 100);

    // stop: start drops while in WAIT; that word is still delivered
    push_exp(8'h10);
    pc_load = 1'b1; pc_load_value = 8'h10;
    next_cycle();
    pc_load = 1'b0;
    next_cycle();
    start = 1'b0;
    #1;
    chk("stop_in_wait", dbg_state, 2);
    wait_valid("wait_stop_word");
    consume_one();
    reads = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (imem_rd_en) reads++;
      next_cycle();
    end
    chk("stop_reads", reads, 0);
    chk("stop_valid", ir_valid, 0);
    chk("stop_state", dbg_state, 0);

    // reset while a read is in flight
    start = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    chk("rst2_in_wait", dbg_state, 2);
    reset_n = 1'b0;
    next_cycle(); #1;
    chk("rst2_valid", ir_valid, 0);
    chk("rst2_ir", IR, 0);
    chk("rst2_ir_pc", ir_pc, 0);
    chk("rst2_rd_en", imem_rd_en, 0);
    reset_n = 1'b1;
    push_exp(8'h00);
    next_cycle(); #1;
    chk("rst2_rd_en_after", imem_rd_en, 1);
    chk("rst2_reset_pc", imem_addr, 8'h00);
    wait_valid("wait_after_reset");
    consume_one();

    repeat (4) next_cycle();
    chk("queue_drained", exp_q.size(), 0);
    summary();
    $finish;
  end
endmodule
